btb_controller: RTL and testbench

BTB_CONTROLLER -- requirements
Module: btb_controller

---
 rtl/btb_controller.sv | 146 ++++++++++++++
 tb/tb_btb_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_controller.sv
// rtl/btb_controller.sv - branch target buffer with a single shared table port
// Lookups are serviced in IDLE; updates do a read-modify-write over UPD_RD/UPD_WR.
module btb_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_req,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  lookup_ready,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  update_req,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_taken,
    output logic                  update_ack
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_e;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } entry_t;

    entry_t                table_q [ENTRIES];
    entry_t                hold_q, hold_d;
    entry_t                rd_entry, wr_entry;
    state_e                state_q, state_d;
    logic                  fair_q, fair_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [ADDR_WIDTH-1:0] pred_target_q, pred_target_d;
    logic [INDEX_BITS-1:0] acc_idx;
    logic                  tbl_we;
    logic                  lk_hit;
    logic                  upd_hit;

    // One access port: IDLE reads for the lookup, update states use the update index.
    assign acc_idx  = (state_q == IDLE) ? lookup_pc[INDEX_BITS-1:0] : update_pc[INDEX_BITS-1:0];
    assign rd_entry = table_q[acc_idx];
    assign lk_hit   = rd_entry.valid && (rd_entry.tag == lookup_pc[ADDR_WIDTH-1:INDEX_BITS]);
    assign upd_hit  = hold_q.valid && (hold_q.tag == update_pc[ADDR_WIDTH-1:INDEX_BITS]);

    always_comb begin
        wr_entry = hold_q;
        if (upd_hit) begin
            if (update_taken) begin
                wr_entry.ctr    = (hold_q.ctr == 2'd3) ? 2'd3 : hold_q.ctr + 2'd1;
                wr_entry.target = update_target;
            end else begin
                wr_entry.ctr = (hold_q.ctr == 2'd0) ? 2'd0 : hold_q.ctr - 2'd1;
            end
        end else begin
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = update_pc[ADDR_WIDTH-1:INDEX_BITS];
            wr_entry.target = update_target;
            wr_entry.ctr    = update_taken ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        fair_d        = fair_q;
        hold_d        = hold_q;
        lookup_ready  = 1'b0;
        update_ack    = 1'b0;
        tbl_we        = 1'b0;
        pred_valid_d  = 1'b0;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        case (state_q)
            IDLE: begin
                if (update_req && !(fair_q && lookup_req)) begin
                    state_d = UPD_RD;
                end else begin
                    lookup_ready = 1'b1;
                    if (lookup_req) begin
                        fair_d       = 1'b0;
                        pred_valid_d = 1'b1;
                        if (lk_hit && rd_entry.ctr[1]) begin
                            pred_taken_d  = 1'b1;
                            pred_target_d = rd_entry.target;
                        end else begin
                            pred_taken_d  = 1'b0;
                            pred_target_d = lookup_pc + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            UPD_RD: begin
                hold_d  = rd_entry;
                state_d = UPD_WR;
            end
            UPD_WR: begin
                tbl_we     = 1'b1;
                update_ack = !reset;
                if (lookup_req) begin
                    fair_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fair_q        <= 1'b0;
            hold_q        <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= 2'd1;
            end
        end else begin
            state_q       <= state_d;
            fair_q        <= fair_d;
            hold_q        <= hold_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            if (tbl_we) begin
                table_q[acc_idx] <= wr_entry;
            end
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_controller.sv
// tb/tb_btb_controller.sv - directed and random checks of btb_controller against a table model
module tb_btb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_req;
    logic [15:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        update_req;
    logic [15:0] update_pc;
    logic [15:0] update_target;
    logic        update_taken;
    logic        update_ack;

    int n_assert = 0;
    int n_fail   = 0;

    int          m_valid [16];
    int          m_tag   [16];
    int          m_tgt   [16];
    int          m_ctr   [16];
    logic        last_tk;
    logic [15:0] last_tg;

    btb_controller #(.ADDR_WIDTH(16), .INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .lookup_req(lookup_req), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_req(update_req), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .update_ack(update_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        last_tk = 1'b0;
        last_tg = 16'h0000;
    endfunction

    function automatic void model_pred(input logic [15:0] pc, output logic tk, output logic [15:0] tg);
        int i;
        i = pc % 16;
        if (m_valid[i] == 1 && m_tag[i] == pc / 16 && m_ctr[i] >= 2) begin
            tk = 1'b1; tg = 16'(m_tgt[i]);
        end else begin
            tk = 1'b0; tg = 16'((int'(pc) + 1) % 65536);
        end
    endfunction

    function automatic void model_update(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        int i;
        i = pc % 16;
        if (m_valid[i] == 1 && m_tag[i] == pc / 16) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = int'(tgt);
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else begin
            m_valid[i] = 1; m_tag[i] = pc / 16; m_tgt[i] = int'(tgt); m_ctr[i] = tk ? 2 : 1;
        end
    endfunction

    task automatic check_pred(input string tag, input logic [15:0] pc);
        logic        etk;
        logic [15:0] etg;
        model_pred(pc, etk, etg);
        check({tag, "_pv"}, pred_valid, 1'b1);
        check({tag, "_tk"}, pred_taken, etk);
        check({tag, "_tg"}, pred_target, etg);
        last_tk = etk;
        last_tg = etg;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_lookup(input logic [15:0] pc);
        lookup_req = 1'b1;
        lookup_pc  = pc;
        #1;
        check("lk_ready", lookup_ready, 1'b1);
        @(posedge clk); #1;
        lookup_req = 1'b0;
        check_pred("lk", pc);
    endtask

    task automatic do_update(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        update_req = 1'b1; update_pc = pc; update_target = tgt; update_taken = tk;
        #1;
        check("upd_grant_ready", lookup_ready, 1'b0);
        check("upd_grant_ack", update_ack, 1'b0);
        @(posedge clk); #1;
        check("upd_rd_ack", update_ack, 1'b0);
        check("upd_rd_ready", lookup_ready, 1'b0);
        check("upd_rd_pv", pred_valid, 1'b0);
        check("upd_hold_tk", pred_taken, last_tk);
        check("upd_hold_tg", pred_target, last_tg);
        @(posedge clk); #1;
        check("upd_wr_ack", update_ack, 1'b1);
        check("upd_wr_ready", lookup_ready, 1'b0);
        model_update(pc, tgt, tk);
        @(posedge clk); #1;
        update_req = 1'b0;
        #1;
        check("upd_done_ack", update_ack, 1'b0);
        check("upd_done_ready", lookup_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] pc;
        reset = 1'b1; lookup_req = 1'b0; lookup_pc = '0;
        update_req = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_pv", pred_valid, 1'b0);
        check("rst_tk", pred_taken, 1'b0);
        check("rst_tg", pred_target, 16'h0000);
        check("rst_ack", update_ack, 1'b0);
        check("rst_ready", lookup_ready, 1'b1);

        do_lookup(16'h0012);
        @(posedge clk); #1;
        check("idle_pv_low", pred_valid, 1'b0);
        check("idle_tg_hold", pred_target, 16'h0013);

        do_update(16'h0012, 16'h0040, 1'b1);
        do_lookup(16'h0012);
        check("taken_hit_tg", pred_target, 16'h0040);

        for (int k = 0; k < 3; k++) begin
            do_update(16'h0012, 16'h0077, 1'b0);
        end
        do_lookup(16'h0012);
        check("sat0_tg", pred_target, 16'h0013);

        do_update(16'h0022, 16'h0090, 1'b1);
        do_lookup(16'h0012);
        check("alias_miss_tk", pred_taken, 1'b0);
        do_lookup(16'h0022);
        check("alias_hit_tg", pred_target, 16'h0090);

        // Lookup held against two back-to-back updates.
        lookup_req = 1'b1; lookup_pc = 16'h0035;
        update_req = 1'b1; update_pc = 16'h0035; update_target = 16'h0100; update_taken = 1'b1;
        #1;
        check("conc_idle0_ready", lookup_ready, 1'b0);
        @(posedge clk); #1;
        check("conc_rd1_ready", lookup_ready, 1'b0);
        check("conc_rd1_ack", update_ack, 1'b0);
        @(posedge clk); #1;
        check("conc_wr1_ready", lookup_ready, 1'b0);
        check("conc_wr1_ack", update_ack, 1'b1);
        model_update(16'h0035, 16'h0100, 1'b1);
        @(posedge clk); #1;
        update_target = 16'h0200; update_taken = 1'b0;
        #1;
        check("conc_fair_ready", lookup_ready, 1'b1);
        check("conc_fair_ack", update_ack, 1'b0);
        @(posedge clk); #1;
        check_pred("conc_lk1", 16'h0035);
        check("conc_lk1_tk_taken", pred_taken, 1'b1);
        check("conc_idle2_ready", lookup_ready, 1'b0);
        @(posedge clk); #1;
        check("conc_rd2_ready", lookup_ready, 1'b0);
        check("conc_rd2_pv", pred_valid, 1'b0);
        @(posedge clk); #1;
        check("conc_wr2_ready", lookup_ready, 1'b0);
        check("conc_wr2_ack", update_ack, 1'b1);
        model_update(16'h0035, 16'h0200, 1'b0);
        @(posedge clk); #1;
        update_req = 1'b0;
        #1;
        check("conc_idle3_ready", lookup_ready, 1'b1);
        @(posedge clk); #1;
        lookup_req = 1'b0;
        check_pred("conc_lk2", 16'h0035);

        for (int k = 0; k < 40; k++) begin
            pc = 16'((($urandom_range(0, 2)) << 4) | $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pc = 16'($urandom);
            if ($urandom_range(0, 2) == 0)
                do_update(pc, 16'($urandom), 1'($urandom_range(0, 1)));
            else
                do_lookup(pc);
        end

        // Reset during UPD_WR aborts the update.
        update_req = 1'b1; update_pc = 16'h0012; update_target = 16'h0050; update_taken = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_ack", update_ack, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; update_req = 1'b0;
        model_reset();
        #1;
        check("abort_ack_after", update_ack, 1'b0);
        check("abort_pv", pred_valid, 1'b0);
        check("abort_tg", pred_target, 16'h0000);
        do_lookup(16'h0012);
        check("abort_miss_tk", pred_taken, 1'b0);
        do_lookup(16'hFFFF);
        check("wrap_tg", pred_target, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
